// File: rtl/sao_pkg.sv
// Shared SAO types, constants and helpers for the offset-apply datapath.
package sao_pkg;

  typedef enum logic [1:0] {
    SAO_OFF = 2'd0,
    SAO_BO  = 2'd1,
    SAO_EO  = 2'd2
  } sao_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_DRAIN
  } sao_state_e;

  localparam int unsigned SAO_N_BANDS = 32;
  localparam int unsigned SAO_N_OFS   = 4;

  function automatic int clip_range(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/sao_ofs_lookup.sv
// Per-pixel category to signed offset lookup (EO class or BO band relative to band_pos).
module sao_ofs_lookup
  import sao_pkg::*;
#(
  parameter int n_bo_type = 5,
  parameter int ofs_bit   = 4
) (
  input  logic [1:0]                     mode,
  input  logic [n_bo_type-1:0]           band_pos,
  input  logic [n_bo_type-1:0]           cate,
  input  logic [SAO_N_OFS*ofs_bit-1:0]   ofs_tbl,
  output logic [ofs_bit-1:0]             ofs
);

  logic [n_bo_type-1:0] k;
  logic [1:0]           idx;
  logic                 hit;

  always_comb begin
    ofs = '0;
    idx = '0;
    hit = 1'b0;
    // Band distance wraps modulo the band count by virtue of the register width.
    k   = cate - band_pos;
    case (sao_type_e'(mode))
      SAO_EO: begin
        if (cate >= n_bo_type'(1) && cate <= n_bo_type'(4)) begin
          hit = 1'b1;
          idx = 2'(cate - n_bo_type'(1));
        end
      end
      SAO_BO: begin
        if (k < n_bo_type'(4)) begin
          hit = 1'b1;
          idx = k[1:0];
        end
      end
      default: hit = 1'b0;
    endcase
    if (hit) ofs = ofs_tbl[int'(idx)*ofs_bit +: ofs_bit];
  end

endmodule

// File: rtl/sao_offset_apply.sv
// SAO offset application: per-CTB offset load, then a two-stage lookup/add/clip pipeline.
module sao_offset_apply
  import sao_pkg::*;
#(
  parameter int PIX2      = 2,
  parameter int bit_depth = 8,
  parameter int n_bo_type = 5,
  parameter int ofs_bit   = 4
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          start,
  input  logic [1:0]                    sao_type,
  input  logic [n_bo_type-1:0]          band_pos,
  input  logic                          ofs_valid,
  input  logic [ofs_bit-1:0]            ofs_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [PIX2*bit_depth-1:0]     rec,
  input  logic [PIX2*n_bo_type-1:0]     cate,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [PIX2*bit_depth-1:0]     out_pix,
  output logic                          busy
);

  sao_state_e                       state_q, state_d;
  sao_type_e                        mode_q;
  logic [n_bo_type-1:0]             band_pos_q;
  logic [SAO_N_OFS*ofs_bit-1:0]     ofs_tbl_q;
  logic [1:0]                       cnt_q;

  logic                             s1_valid, s1_last;
  logic [PIX2*bit_depth-1:0]        s1_rec;
  logic [PIX2*ofs_bit-1:0]          s1_ofs, lut_ofs;
  logic [PIX2*bit_depth-1:0]        pix_d;

  logic advance, s1_en, accept;
  logic cfg_cap, tbl_clr, ofs_we;

  function automatic sao_type_e decode_type(input logic [1:0] t);
    case (t)
      2'd1:    return SAO_BO;
      2'd2:    return SAO_EO;
      default: return SAO_OFF;
    endcase
  endfunction

  assign advance = !out_valid || out_ready;
  assign s1_en   = !s1_valid || advance;
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = (state_q != ST_IDLE);
    cfg_cap  = 1'b0;
    tbl_clr  = 1'b0;
    ofs_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_cap = 1'b1;
          if (decode_type(sao_type) == SAO_OFF) begin
            tbl_clr = 1'b1;
            state_d = ST_APPLY;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        ofs_we = ofs_valid;
        if (ofs_valid && cnt_q == 2'd3) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        in_ready = s1_en;
        if (in_valid && s1_en && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_valid && out_ready && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mode_q     <= SAO_OFF;
      band_pos_q <= '0;
      ofs_tbl_q  <= '0;
      cnt_q      <= '0;
    end else begin
      if (cfg_cap) begin
        mode_q     <= decode_type(sao_type);
        band_pos_q <= band_pos;
        cnt_q      <= '0;
        if (tbl_clr) ofs_tbl_q <= '0;
      end
      if (ofs_we) begin
        ofs_tbl_q[int'(cnt_q)*ofs_bit +: ofs_bit] <= ofs_in;
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  for (genvar g = 0; g < PIX2; g++) begin : g_lut
    sao_ofs_lookup #(
      .n_bo_type (n_bo_type),
      .ofs_bit   (ofs_bit)
    ) u_lut (
      .mode     (mode_q),
      .band_pos (band_pos_q),
      .cate     (cate[g*n_bo_type +: n_bo_type]),
      .ofs_tbl  (ofs_tbl_q),
      .ofs      (lut_ofs[g*ofs_bit +: ofs_bit])
    );
  end

  // Stage 1 drains on advance in any state; it only refills while accepting in APPLY.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_rec   <= '0;
      s1_ofs   <= '0;
    end else if (s1_en) begin
      s1_valid <= accept;
      s1_last  <= in_last;
      s1_rec   <= rec;
      s1_ofs   <= lut_ofs;
    end
  end

  always_comb begin
    logic signed [bit_depth+1:0] sum;
    sum   = '0;
    pix_d = '0;
    for (int unsigned i = 0; i < PIX2; i++) begin
      sum = {2'b00, s1_rec[i*bit_depth +: bit_depth]}
          + {{(bit_depth+2-ofs_bit){s1_ofs[i*ofs_bit+ofs_bit-1]}}, s1_ofs[i*ofs_bit +: ofs_bit]};
      pix_d[i*bit_depth +: bit_depth] = bit_depth'(clip_range(int'(sum), (1 << bit_depth) - 1));
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pix   <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      out_pix   <= pix_d;
    end
  end

endmodule

// File: tb/tb_sao_offset_apply.sv
// Directed bench for sao_offset_apply: EO/BO lookup, clipping, backpressure, bypass and reset.
module tb_sao_offset_apply;

  localparam int PIX2 = 2;
  localparam int BD   = 8;
  localparam int NB   = 5;
  localparam int OB   = 4;

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic                 start = 1'b0;
  logic [1:0]           sao_type = '0;
  logic [NB-1:0]        band_pos = '0;
  logic                 ofs_valid = 1'b0;
  logic [OB-1:0]        ofs_in = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_last = 1'b0;
  logic [PIX2*BD-1:0]   rec = '0;
  logic [PIX2*NB-1:0]   cate = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_last;
  logic [PIX2*BD-1:0]   out_pix;
  logic                 busy;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int rdy_mode = 0;
  int inflight = 0;
  int bal      = -1;
  bit last_pend = 1'b0;

  logic [15:0] pix_q[$];
  bit          last_q[$];
  int          acc_q[$];
  int          ocyc_q[$];

  always #5 clk = ~clk;

  sao_offset_apply #(
    .PIX2      (PIX2),
    .bit_depth (BD),
    .n_bo_type (NB),
    .ofs_bit   (OB)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .sao_type  (sao_type),
    .band_pos  (band_pos),
    .ofs_valid (ofs_valid),
    .ofs_in    (ofs_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .rec       (rec),
    .cate      (cate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_pix   (out_pix),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // out_ready pattern generator: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = stalled
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    case (rdy_mode)
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (!arst_n) begin
      inflight  = 0;
      last_pend = 1'b0;
    end else begin
      if (last_pend) begin
        bal = int'(busy);
        last_pend = 1'b0;
      end
      if (rdy_mode == 1 && inflight == 2 && !out_ready)
        check("inrdy_full", in_ready, 0);
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc);
        inflight++;
      end
      if (out_valid && out_ready) begin
        pix_q.push_back(out_pix);
        last_q.push_back(out_last);
        ocyc_q.push_back(cyc);
        inflight--;
        if (out_last) last_pend = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_q();
    pix_q.delete();
    last_q.delete();
    acc_q.delete();
    ocyc_q.delete();
    bal = -1;
  endtask

  task automatic start_ctb(input logic [1:0] t, input logic [NB-1:0] bp);
    start = 1'b1;
    sao_type = t;
    band_pos = bp;
    @(posedge clk); #1;
    start = 1'b0;
    sao_type = '0;
    band_pos = '0;
  endtask

  task automatic load_ofs(input int a, input int b, input int c, input int d);
    int v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      ofs_valid = 1'b1;
      ofs_in = 4'(v[i]);
      @(posedge clk); #1;
    end
    ofs_valid = 1'b0;
  endtask

  task automatic send_beat(input int r0, input int r1, input int c0, input int c1, input bit last);
    bit ok;
    ok = 1'b0;
    rec = {8'(r1), 8'(r0)};
    cate = {5'(c1), 5'(c0)};
    in_last = last;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    for (int k = 0; k < 300; k++) begin
      if (pix_q.size() >= n) break;
      @(negedge clk);
    end
    if (pix_q.size() < n) check("out_timeout", pix_q.size(), n);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_pix(input string tag, input int idx, input int e0, input int e1, input bit el);
    logic [15:0] p;
    p = pix_q[idx];
    check({tag, "_p0"}, p[7:0], e0);
    check({tag, "_p1"}, p[15:8], e1);
    check({tag, "_last"}, last_q[idx], el);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    arst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 0);

    // EO basic with latency
    clear_q();
    start_ctb(2'd2, 5'd0);
    check("eo_busy", busy, 1);
    load_ofs(3, 1, -1, -3);
    send_beat(100, 100, 1, 4, 1'b1);
    wait_outs(1);
    check_pix("eo", 0, 103, 97, 1'b1);
    check("eo_latency", ocyc_q[0] - acc_q[0], 2);
    wait_idle();

    // BO with band wrap-around
    clear_q();
    start_ctb(2'd1, 5'd30);
    load_ofs(2, 4, 6, 7);
    send_beat(50, 60, 31, 1, 1'b0);
    send_beat(80, 90, 2, 30, 1'b1);
    wait_outs(2);
    check_pix("bo0", 0, 54, 67, 1'b0);
    check_pix("bo1", 1, 80, 92, 1'b1);
    wait_idle();

    // Clipping at both ends, out-of-range EO classes
    clear_q();
    start_ctb(2'd2, 5'd0);
    load_ofs(7, 0, 0, -7);
    send_beat(252, 3, 1, 4, 1'b0);
    send_beat(0, 255, 4, 1, 1'b0);
    send_beat(10, 20, 0, 5, 1'b1);
    wait_outs(3);
    check_pix("clip0", 0, 255, 0, 1'b0);
    check_pix("clip1", 1, 0, 255, 1'b0);
    check_pix("eo_none", 2, 10, 20, 1'b1);
    wait_idle();

    // Backpressure with 1-0-0-1 out_ready
    clear_q();
    start_ctb(2'd2, 5'd0);
    load_ofs(1, 2, 3, 4);
    rdy_mode = 1;
    for (int b = 0; b < 8; b++)
      send_beat(10*b + 5, 10*b + 100, 1, 2, b == 7);
    wait_outs(8);
    rdy_mode = 0;
    wait_idle();
    check("bp_count", pix_q.size(), 8);
    for (int b = 0; b < 8; b++)
      check_pix($sformatf("bp%0d", b), b, 10*b + 6, 10*b + 102, b == 7);

    // Bypass: table zeroed, ofs_valid ignored, busy drop timing
    clear_q();
    start_ctb(2'd0, 5'd0);
    ofs_valid = 1'b1;
    ofs_in = 4'd5;
    @(posedge clk); #1;
    ofs_valid = 1'b0;
    send_beat(17, 200, 1, 4, 1'b0);
    send_beat(255, 0, 31, 2, 1'b1);
    wait_outs(2);
    wait_idle();
    @(negedge clk); #1;
    check_pix("off0", 0, 17, 200, 1'b0);
    check_pix("off1", 1, 255, 0, 1'b1);
    check("busy_drop", bal, 0);

    clear_q();
    start_ctb(2'd3, 5'd0);
    send_beat(9, 250, 1, 4, 1'b1);
    wait_outs(1);
    check_pix("type3", 0, 9, 250, 1'b1);
    wait_idle();

    // Reset with two beats in flight
    clear_q();
    rdy_mode = 2;
    start_ctb(2'd2, 5'd0);
    load_ofs(5, 5, 5, 5);
    send_beat(1, 2, 1, 1, 1'b0);
    send_beat(3, 4, 1, 1, 1'b0);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_out_pix", out_pix, 0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);
    clear_q();
    start_ctb(2'd2, 5'd0);
    load_ofs(-2, 0, 0, 0);
    send_beat(40, 41, 1, 1, 1'b1);
    wait_outs(1);
    wait_idle();
    check("post_rst_count", pix_q.size(), 1);
    check_pix("post_rst", 0, 38, 39, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sao_offset_apply.md
SAO_OFFSET_APPLY -- requirements
Module: sao_offset_apply

Interface
REQ-001 Parameter PIX2, default 2: pixels processed per beat.
REQ-002 Parameter bit_depth, default 8: sample width.
REQ-003 Parameter n_bo_type, default 5: category/band-index width (32 bands).
REQ-004 Parameter ofs_bit, default 4: signed offset width.
REQ-005 clk  in  1  sole clock; one clock, all state on rising edge.
REQ-006 arst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle pulse opening a CTB; sampled only in IDLE.
REQ-008 sao_type  in  2  0 off, 1 band offset (BO), 2 edge offset (EO), 3 treated as off; sampled with start.
REQ-009 band_pos  in  n_bo_type  first BO band; sampled with start.
REQ-010 ofs_valid / ofs_in  in  1 / ofs_bit signed  offset load beat, four beats per CTB, in order ofs[0..3].
REQ-011 in_valid / in_ready  in / out  1  pixel-beat handshake; in_last in 1 marks the final beat of the CTB.
REQ-012 rec[0:PIX2-1]  in  bit_depth unsigned  reconstructed samples.
REQ-013 cate[0:PIX2-1]  in  n_bo_type  per-pixel category: EO class 0..4, or BO band index.
REQ-014 out_valid / out_ready  out / in  1  output handshake; out_last out 1 mirrors in_last.
REQ-015 out_pix[0:PIX2-1]  out  bit_depth  offset-corrected samples.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, LOAD, APPLY, DRAIN.
- IDLE->LOAD on start with sao_type 1 or 2.
- IDLE->APPLY on start with sao_type 0/3; offset table zeroed.
REQ-018 LOAD: 2-bit counter accepts ofs_in on each ofs_valid; ofs_valid ignored outside LOAD; after the 4th beat -> APPLY next cycle.
REQ-019 APPLY: in_ready = !s1_valid || advance, where advance = !out_valid || out_ready.
- Accepting a beat with in_last -> DRAIN; in_ready low in DRAIN.
REQ-020 DRAIN -> IDLE in the cycle the beat carrying out_last is accepted (out_valid && out_ready).
REQ-021 Two-stage pipeline.
- Stage 1 registers rec and the looked-up offset.
- Stage 2 registers the clipped sum.
- out_valid is asserted 2 cycles after input acceptance when out_ready is held high.
- Full throughput: one beat per cycle.
REQ-022 EO lookup: cate 1..4 -> ofs[cate-1]; cate 0 or >4 -> 0.
REQ-023 BO lookup: k = (cate - band_pos) mod 2^n_bo_type; k<4 -> ofs[k], else 0.
- Wrap-around is mandatory: band_pos 30 covers bands 30, 31, 0, 1.
REQ-024 Arithmetic: offset sign-extended to bit_depth+2 bits; sum = rec + ofs; result clipped to [0, 2^bit_depth-1].
REQ-025 Backpressure: with out_ready low and out_valid high, both stages hold; no beat is lost or duplicated.
REQ-026 start while busy is ignored; the offset table and sao_type stay constant until the next IDLE.

Reset
REQ-027 arst_n low asynchronously forces IDLE; clears counter, offset table, and both stage valids.
- Outputs: out_valid 0, out_last 0, out_pix 0, in_ready 0, busy 0.
REQ-028 Reset mid-operation (LOAD/APPLY/DRAIN) discards all in-flight beats; the next CTB requires a new start.

Structure
REQ-029 Shared package sao_pkg holds: sao_type enum (SAO_OFF, SAO_BO, SAO_EO), FSM state enum, the band count constant, and the clip-range function.
REQ-030 One sub-module sao_ofs_lookup: combinational, per-pixel category -> signed offset; instantiated PIX2 times.

Verification
REQ-031 EO, ofs {3,1,-1,-3}, rec {100,100}, cate {1,4}, out_ready=1 -> out_pix {103,97}, out_valid two cycles after acceptance.
REQ-032 BO, band_pos 30, ofs {2,4,6,7}, cate {31,1}, rec {50,60} -> {54,67}; cate 2 -> unchanged.
REQ-033 Clipping: EO, ofs[0]=7, rec 252 -> 255; ofs[3]=-7, rec 3 -> 0.
REQ-034 Backpressure: 8 beats, out_ready toggled 1-0-0-1 pattern -> all 8 outputs in order, none duplicated; in_ready low while both stages full.
REQ-035 sao_type 0 -> no LOAD, out_pix equals rec; out_last follows in_last; busy drops one cycle after the last output handshake.
REQ-036 arst_n pulsed during APPLY with 2 beats in flight -> out_valid 0 immediately; next start with a fresh table yields correct results.
